// File: rtl/operand_mem_sequencer_if.sv
// Memory-bus bundle shared by the operand sequencer and the memory/arbiter side.
//   bus_req/bus_gnt      : bus arbitration
//   mem_addr/mem_rd/mem_wr/mem_wdata : access request from the sequencer
//   mem_rdata/mem_ack    : completion from memory
// master = sequencer side, slave = memory side.
interface operand_mem_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output bus_req, mem_addr, mem_rd, mem_wr, mem_wdata,
        input  bus_gnt, mem_rdata, mem_ack
    );

    modport slave (
        input  bus_req, mem_addr, mem_rd, mem_wr, mem_wdata,
        output bus_gnt, mem_rdata, mem_ack
    );
endinterface

// File: rtl/operand_mem_sequencer.sv
// Operand fetch / result write-back sequencer between the control FSM and the
// shared memory bus. Registers live in memory at base + idx*(DATA_W/8).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   base_ld, base_addr  latch register-file base (IDLE only)
//   rd_start, wr_start  start operand fetch / write-back (pulses)
//   op_idx/op_ptr/op_imm per-operand index, pointer-indirection and immediate flags
//   dst_idx/dst_ptr/dst_data write-back destination and data
//   bus                 memory bus (master modport)
//   op_data             fetched operands, op k at [k*DATA_W +: DATA_W]
//   rd_done, wr_done    completion pulses
//   busy                operation in progress
//   err                 timeout abort or rejected start (pulse)
module operand_mem_sequencer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int IDX_W   = 4,
    parameter int NUM_OPS = 3,
    parameter int IMM_VAL = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       base_ld,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic                       rd_start,
    input  logic                       wr_start,
    input  logic [NUM_OPS*IDX_W-1:0]   op_idx,
    input  logic [NUM_OPS-1:0]         op_ptr,
    input  logic [NUM_OPS-1:0]         op_imm,
    input  logic [IDX_W-1:0]           dst_idx,
    input  logic                       dst_ptr,
    input  logic [DATA_W-1:0]          dst_data,
    operand_mem_sequencer_if.master    bus,
    output logic [NUM_OPS*DATA_W-1:0]  op_data,
    output logic                       rd_done,
    output logic                       wr_done,
    output logic                       busy,
    output logic                       err
);
    localparam int CW    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int BYTES = DATA_W / 8;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_OPS - 1);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, FIN} state_t;

    typedef struct packed {
        logic                     is_wr;
        logic [NUM_OPS*IDX_W-1:0] idx;
        logic [NUM_OPS-1:0]       ptr;
        logic [NUM_OPS-1:0]       imm;
        logic [IDX_W-1:0]         dst_idx;
        logic                     dst_ptr;
        logic [DATA_W-1:0]        dst_data;
    } cmd_t;

    state_t            state, state_nx;
    cmd_t              cmd;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] ptr_addr;   // pointer value fetched by the first read
    logic              ind;        // second (indirect) access of the current item
    logic [CW-1:0]     ch;
    logic [TW-1:0]     wcnt;

    logic [IDX_W-1:0]  cur_idx;
    logic              cur_ptr, cur_imm;
    logic [ADDR_W-1:0] reg_addr, acc_addr;
    logic              start, last_ch, imm_slot, wr_phase, need_ind, timeout_hit;

    // Per-channel command fields of the channel being worked on
    always_comb begin
        cur_idx = '0;
        cur_ptr = 1'b0;
        cur_imm = 1'b0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (CW'(k) == ch) begin
                cur_idx = cmd.idx[k*IDX_W +: IDX_W];
                cur_ptr = cmd.ptr[k];
                cur_imm = cmd.imm[k];
            end
        end
    end

    assign start    = rd_start | wr_start;
    assign last_ch  = (ch == LAST_CH);
    assign imm_slot = !cmd.is_wr && cur_imm;
    // A pointer write-back reads the dst register first; only the second access writes
    assign wr_phase = cmd.is_wr && !(cmd.dst_ptr && !ind);
    assign need_ind = !ind && (cmd.is_wr ? cmd.dst_ptr : cur_ptr);
    assign reg_addr = base + ADDR_W'(cmd.is_wr ? cmd.dst_idx : cur_idx) * ADDR_W'(BYTES);
    assign acc_addr = ind ? ptr_addr : reg_addr;
    assign timeout_hit = (TIMEOUT != 0) && (state == WAIT) && !bus.mem_ack && (wcnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.bus_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_wdata = '0;
        busy          = 1'b0;
        rd_done       = 1'b0;
        wr_done       = 1'b0;
        case (state)
            IDLE: if (start) state_nx = ARB;
            ARB: begin
                busy        = 1'b1;
                bus.bus_req = 1'b1;
                if (bus.bus_gnt) state_nx = ISSUE;
            end
            ISSUE: begin
                busy        = 1'b1;
                bus.bus_req = 1'b1;
                if (imm_slot) begin
                    state_nx = last_ch ? FIN : ISSUE;
                end else begin
                    bus.mem_addr  = acc_addr;
                    bus.mem_rd    = !wr_phase;
                    bus.mem_wr    = wr_phase;
                    bus.mem_wdata = wr_phase ? cmd.dst_data : '0;
                    state_nx      = WAIT;
                end
            end
            WAIT: begin
                busy          = 1'b1;
                bus.bus_req   = 1'b1;
                bus.mem_addr  = acc_addr;
                bus.mem_wdata = wr_phase ? cmd.dst_data : '0;
                if (bus.mem_ack) begin
                    if (need_ind)                  state_nx = ISSUE;
                    else if (cmd.is_wr || last_ch) state_nx = FIN;
                    else                           state_nx = ISSUE;
                end else if (timeout_hit) begin
                    state_nx = IDLE;
                end
            end
            FIN: begin
                rd_done  = !cmd.is_wr;
                wr_done  = cmd.is_wr;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base     <= '0;
            cmd      <= '0;
            ptr_addr <= '0;
            ind      <= 1'b0;
            ch       <= '0;
            wcnt     <= '0;
            op_data  <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (base_ld) base <= base_addr;
                    if (start) begin
                        // Simultaneous starts: the read wins, the write is reported
                        cmd <= '{is_wr: !rd_start, idx: op_idx, ptr: op_ptr, imm: op_imm,
                                 dst_idx: dst_idx, dst_ptr: dst_ptr, dst_data: dst_data};
                        ch   <= '0;
                        ind  <= 1'b0;
                        wcnt <= '0;
                        err  <= rd_start & wr_start;
                    end
                end
                ISSUE: begin
                    wcnt <= '0;
                    if (imm_slot) begin
                        for (int k = 0; k < NUM_OPS; k++)
                            if (CW'(k) == ch) op_data[k*DATA_W +: DATA_W] <= DATA_W'(IMM_VAL);
                        ch <= ch + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.mem_ack) begin
                        wcnt <= '0;
                        if (need_ind) begin
                            ptr_addr <= ADDR_W'(bus.mem_rdata);
                            ind      <= 1'b1;
                        end else if (!cmd.is_wr) begin
                            for (int k = 0; k < NUM_OPS; k++)
                                if (CW'(k) == ch) op_data[k*DATA_W +: DATA_W] <= bus.mem_rdata;
                            ind <= 1'b0;
                            ch  <= ch + 1'b1;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                        if (timeout_hit) err <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (state != IDLE && start) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_operand_mem_sequencer.sv
module tb_operand_mem_sequencer;
    localparam int DW = 32, AW = 32, IW = 4, NO = 3, TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          base_ld = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          rd_start = 1'b0, wr_start = 1'b0;
    logic [11:0]   op_idx = '0;
    logic [2:0]    op_ptr = '0, op_imm = '0;
    logic [3:0]    dst_idx = '0;
    logic          dst_ptr = 1'b0;
    logic [31:0]   dst_data = '0;
    logic [95:0]   op_data;
    logic          rd_done, wr_done, busy, err;

    operand_mem_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    operand_mem_sequencer #(.DATA_W(DW), .ADDR_W(AW), .IDX_W(IW), .NUM_OPS(NO),
                            .IMM_VAL(1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .base_ld(base_ld), .base_addr(base_addr),
        .rd_start(rd_start), .wr_start(wr_start), .op_idx(op_idx), .op_ptr(op_ptr),
        .op_imm(op_imm), .dst_idx(dst_idx), .dst_ptr(dst_ptr), .dst_data(dst_data),
        .bus(bus.master), .op_data(op_data), .rd_done(rd_done), .wr_done(wr_done),
        .busy(busy), .err(err));

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    logic [31:0] mem [logic [31:0]];
    acc_t  log_q[$], exp_q[$];
    int    checks = 0, errors = 0;
    int    cyc = 0, rd_cnt = 0, wr_cnt = 0, err_cnt = 0, err_cyc = 0, strobe_cyc = 0;
    int    lat = 1, pend_cnt = 0;
    logic  withhold = 1'b0, gnt_always = 1'b1;
    logic [31:0] pend_data = '0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory / arbiter model: ack arrives `lat` cycles after the strobe
    initial begin
        acc_t a;
        bus.bus_gnt = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0; bus.mem_rdata = '0;
            bus.bus_gnt = bus.bus_req && (gnt_always || ($urandom_range(0, 1) == 1));
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0 && !withhold) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = pend_data;
                end
            end
            if (bus.mem_rd || bus.mem_wr) begin
                a.wr = bus.mem_wr; a.addr = bus.mem_addr;
                a.data = bus.mem_wr ? bus.mem_wdata : 32'h0;
                log_q.push_back(a);
                pend_data = bus.mem_wr ? 32'h0 : memval(bus.mem_addr);
                if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
                pend_cnt = lat;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rd_done) rd_cnt++;
        if (wr_done) wr_cnt++;
        if (err) begin err_cnt++; err_cyc = cyc; end
        if (bus.mem_rd || bus.mem_wr) strobe_cyc = cyc;
        if (rd_done || wr_done) chk("done_idle", {busy, bus.bus_req}, 0);
    end

    task automatic set_base(input logic [31:0] b);
        @(negedge clk); base_ld = 1'b1; base_addr = b;
        @(negedge clk); base_ld = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [11:0] idx,
                         input logic [2:0] ptr, input logic [2:0] imm, input logic [3:0] di,
                         input logic dp, input logic [31:0] dd);
        @(negedge clk);
        rd_start = rd; wr_start = wr; op_idx = idx; op_ptr = ptr; op_imm = imm;
        dst_idx = di; dst_ptr = dp; dst_data = dd;
        @(negedge clk);
        rd_start = 1'b0; wr_start = 1'b0;
    endtask

    // Run one command; returns once a done pulse, or an err with the DUT idle, is seen
    task automatic run_op(input logic rd, input logic wr, input logic [11:0] idx,
                          input logic [2:0] ptr, input logic [2:0] imm, input logic [3:0] di,
                          input logic dp, input logic [31:0] dd);
        int d0, e0;
        bit fin;
        log_q.delete();
        d0 = rd_cnt + wr_cnt; e0 = err_cnt; fin = 0;
        drive(rd, wr, idx, ptr, imm, di, dp, dd);
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk); #1;
            if ((rd_cnt + wr_cnt) != d0 || (err_cnt != e0 && !busy)) fin = 1;
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL op_timeout actual=busy required=completion within 300 cycles");
        end
        @(negedge clk);
    endtask

    task automatic model(input logic is_wr, input logic [11:0] idx, input logic [2:0] ptr,
                         input logic [2:0] imm, input logic [3:0] di, input logic dp,
                         input logic [31:0] dd, input logic [31:0] b, inout logic [95:0] opd);
        acc_t e;
        logic [31:0] ra, pa;
        exp_q.delete();
        if (!is_wr) begin
            for (int k = 0; k < 3; k++) begin
                if (imm[k]) opd[k*32 +: 32] = 32'd1;
                else begin
                    ra = b + {28'h0, idx[k*4 +: 4]} * 32'd4;
                    e = '{1'b0, ra, 32'h0}; exp_q.push_back(e);
                    if (ptr[k]) begin
                        pa = memval(ra);
                        e = '{1'b0, pa, 32'h0}; exp_q.push_back(e);
                        opd[k*32 +: 32] = memval(pa);
                    end else opd[k*32 +: 32] = memval(ra);
                end
            end
        end else begin
            ra = b + {28'h0, di} * 32'd4;
            if (dp) begin
                e = '{1'b0, ra, 32'h0}; exp_q.push_back(e);
                e = '{1'b1, memval(ra), dd}; exp_q.push_back(e);
            end else begin
                e = '{1'b1, ra, dd}; exp_q.push_back(e);
            end
        end
    endtask

    typedef struct {
        logic        is_wr;
        logic [11:0] idx;
        logic [2:0]  ptr, imm;
        logic [3:0]  di;
        logic        dp;
        logic [31:0] dd;
        int          n_acc;
        logic [31:0] first_a, last_a;
        logic [95:0] opd;
        logic [31:0] chk_a, chk_d;
    } vec_t;

    vec_t vt[6];

    initial begin
        int d_rd, d_wr, d_er, e_total, nw;
        bit ok;
        logic [95:0] prev, exp_opd;
        logic [31:0] cur_base;
        logic is_wr, dp;
        logic [11:0] idx;
        logic [2:0] ptr, imm;
        logic [3:0] di;
        logic [31:0] dd;

        vt[0] = '{0, 12'h752, 3'b000, 3'b000, 4'd0, 0, 32'h0, 3, 32'h108, 32'h11C,
                  {32'h3000, 32'h2000, 32'h11}, 32'h0, 32'h0};
        vt[1] = '{0, 12'h752, 3'b010, 3'b000, 4'd0, 0, 32'h0, 4, 32'h108, 32'h11C,
                  {32'h3000, 32'hDEAD, 32'h11}, 32'h0, 32'h0};
        vt[2] = '{0, 12'h752, 3'b000, 3'b111, 4'd0, 0, 32'h0, 0, 32'h0, 32'h0,
                  {32'h1, 32'h1, 32'h1}, 32'h0, 32'h0};
        vt[3] = '{1, 12'h000, 3'b000, 3'b000, 4'd3, 1, 32'h55, 2, 32'h10C, 32'h40,
                  {32'h1, 32'h1, 32'h1}, 32'h40, 32'h55};
        vt[4] = '{0, 12'h1F0, 3'b100, 3'b010, 4'd0, 0, 32'h0, 3, 32'h100, 32'h40,
                  {32'h55, 32'h1, 32'hAA}, 32'h0, 32'h0};
        vt[5] = '{1, 12'h000, 3'b000, 3'b000, 4'd1, 0, 32'h77, 1, 32'h104, 32'h104,
                  {32'h55, 32'h1, 32'hAA}, 32'h104, 32'h77};
        mem[32'h108] = 32'h11;   mem[32'h114] = 32'h2000; mem[32'h2000] = 32'hDEAD;
        mem[32'h11C] = 32'h3000; mem[32'h10C] = 32'h40;   mem[32'h100] = 32'hAA;
        mem[32'h104] = 32'h40;

        repeat (3) @(negedge clk);
        chk("reset_outs", {bus.bus_req, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
                           rd_done, wr_done, busy, err}, 0);
        chk("reset_opdata", op_data, 0);
        rst = 1'b0;

        // Directed table
        set_base(32'h100);
        lat = 1; gnt_always = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d_rd = rd_cnt; d_wr = wr_cnt; d_er = err_cnt;
            run_op(!vt[i].is_wr, vt[i].is_wr, vt[i].idx, vt[i].ptr, vt[i].imm,
                   vt[i].di, vt[i].dp, vt[i].dd);
            chk($sformatf("tbl%0d_done", i), {rd_cnt - d_rd, wr_cnt - d_wr, err_cnt - d_er},
                {32'(!vt[i].is_wr), 32'(vt[i].is_wr), 32'd0});
            chk($sformatf("tbl%0d_nacc", i), log_q.size(), vt[i].n_acc);
            if (log_q.size() > 0 && vt[i].n_acc > 0) begin
                chk($sformatf("tbl%0d_first", i), log_q[0].addr, vt[i].first_a);
                chk($sformatf("tbl%0d_last", i), log_q[log_q.size()-1].addr, vt[i].last_a);
            end
            chk($sformatf("tbl%0d_opdata", i), op_data, vt[i].opd);
            if (vt[i].is_wr) chk($sformatf("tbl%0d_wmem", i), memval(vt[i].chk_a), vt[i].chk_d);
        end

        // Timeout with ack withheld
        prev = op_data; withhold = 1'b1;
        d_rd = rd_cnt; d_er = err_cnt;
        run_op(1, 0, 12'h111, 3'b000, 3'b000, 4'd0, 0, 32'h0);
        chk("to_err", {rd_cnt - d_rd, err_cnt - d_er}, {32'd0, 32'd1});
        chk("to_wait_cycles", err_cyc - strobe_cyc, TO + 1);
        chk("to_idle", {bus.bus_req, busy}, 0);
        chk("to_opdata_kept", op_data, prev);
        withhold = 1'b0; pend_cnt = 0;
        repeat (2) @(negedge clk);

        // Simultaneous starts: read accepted, write dropped
        e_total = err_cnt; d_rd = rd_cnt; d_wr = wr_cnt;
        run_op(1, 1, 12'h752, 3'b000, 3'b000, 4'd2, 0, 32'h99);
        if (rd_cnt == d_rd) begin
            for (int c = 0; c < 50 && rd_cnt == d_rd; c++) @(negedge clk);
        end
        nw = 0;
        foreach (log_q[j]) if (log_q[j].wr) nw++;
        chk("dual_start", {rd_cnt - d_rd, wr_cnt - d_wr, 32'(nw)}, {32'd1, 32'd0, 32'd0});

        // Start and base_ld while busy: err, base kept
        lat = 3; log_q.delete(); d_rd = rd_cnt;
        drive(1, 0, 12'h752, 3'b000, 3'b000, 4'd0, 0, 32'h0);
        repeat (2) @(negedge clk);
        rd_start = 1'b1; base_ld = 1'b1; base_addr = 32'hFFF0;
        @(negedge clk);
        rd_start = 1'b0; base_ld = 1'b0;
        for (int c = 0; c < 100 && rd_cnt == d_rd; c++) @(negedge clk);
        @(negedge clk);
        chk("busy_start_err", err_cnt - e_total, 2);
        chk("busy_base_kept", {32'(log_q.size()), log_q.size() > 0 ? log_q[0].addr : 32'h0},
            {32'd3, 32'h108});

        // Reset mid-fetch
        drive(1, 0, 12'h752, 3'b000, 3'b000, 4'd0, 0, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {bus.bus_req, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
                            rd_done, wr_done, busy, err}, 0);
        chk("midrst_opdata", op_data, 0);
        rst = 1'b0; pend_cnt = 0; lat = 1;
        run_op(1, 0, 12'h002, 3'b000, 3'b000, 4'd0, 0, 32'h0);
        chk("rst_base_zero", log_q.size() > 0 ? log_q[0].addr : 32'hFFFF_FFFF, 32'h8);

        // Randomized commands against the reference model
        cur_base = 32'h100; set_base(cur_base); exp_opd = '0;
        for (int n = 0; n < 40; n++) begin
            if (n == 5) begin cur_base = 32'hFFFF_FFF0; set_base(cur_base); end
            else if ($urandom_range(0, 3) == 0) begin
                cur_base = $urandom & 32'hFFFF_FFFC; set_base(cur_base);
            end
            is_wr = (n != 0) && ($urandom_range(0, 2) == 0);
            idx = 12'($urandom); ptr = 3'($urandom); imm = 3'($urandom & $urandom);
            di = 4'($urandom); dp = 1'($urandom); dd = $urandom;
            lat = $urandom_range(1, 3); gnt_always = 1'($urandom);
            model(is_wr, idx, ptr, imm, di, dp, dd, cur_base, exp_opd);
            d_rd = rd_cnt; d_wr = wr_cnt; d_er = err_cnt;
            run_op(!is_wr, is_wr, idx, ptr, imm, di, dp, dd);
            chk($sformatf("rnd%0d_done", n), {rd_cnt - d_rd, wr_cnt - d_wr, err_cnt - d_er},
                {32'(!is_wr), 32'(is_wr), 32'd0});
            ok = (log_q.size() == exp_q.size());
            if (ok) foreach (exp_q[j])
                if (log_q[j].wr !== exp_q[j].wr || log_q[j].addr !== exp_q[j].addr ||
                    log_q[j].data !== exp_q[j].data) ok = 0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rnd%0d_accesses actual=%0d accesses first=%0h required=%0d accesses first=%0h",
                         n, log_q.size(), log_q.size() > 0 ? log_q[0].addr : 32'h0,
                         exp_q.size(), exp_q.size() > 0 ? exp_q[0].addr : 32'h0);
            end
            chk($sformatf("rnd%0d_opdata", n), op_data, exp_opd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
